// File: rtl/traffic_light_monitor_pkg.sv
// -----------------------------------------------------------------------------
// traffic_light_monitor_pkg
// Shared definitions for the traffic light monitor slice:
//   phase_e      - decoded lamp phase (OFF, RED, GREEN, YELLOW)
//   mon_state_e  - checker state (SYNC while hunting for a red entry, TRACK
//                  while following a locked R->G->Y->R sequence)
//   CYCLES_W     - width of the completed-cycle counter
//   is_legal_step- true for the three permitted phase successions
// -----------------------------------------------------------------------------
package traffic_light_monitor_pkg;

   typedef enum logic [1:0] {
      PH_OFF    = 2'd0,
      PH_RED    = 2'd1,
      PH_GREEN  = 2'd2,
      PH_YELLOW = 2'd3
   } phase_e;

   typedef enum logic {
      ST_SYNC  = 1'b0,
      ST_TRACK = 1'b1
   } mon_state_e;

   localparam int CYCLES_W = 16;

   // Permitted successions: RED->GREEN, GREEN->YELLOW, YELLOW->RED.
   function automatic logic is_legal_step(input phase_e from_ph, input phase_e to_ph);
      logic legal;
      case (from_ph)
         PH_RED:    legal = (to_ph == PH_GREEN);
         PH_GREEN:  legal = (to_ph == PH_YELLOW);
         PH_YELLOW: legal = (to_ph == PH_RED);
         default:   legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage

// File: rtl/traffic_lamp_decode.sv
// -----------------------------------------------------------------------------
// traffic_lamp_decode
// Combinational decode of the three lamp lines into a phase.
//   red, yellow, green : lamp lines (inputs)
//   phase              : decoded phase; OFF when no lamp or several lamps lit
//   multi_hot          : high when two or more lamps are lit
// -----------------------------------------------------------------------------
module traffic_lamp_decode
   import traffic_light_monitor_pkg::*;
(
   input  logic   red,
   input  logic   yellow,
   input  logic   green,
   output phase_e phase,
   output logic   multi_hot
);

   // One-hot decode; any multi-hot pattern reports OFF and raises multi_hot.
   always_comb begin
      phase     = PH_OFF;
      multi_hot = 1'b0;
      case ({red, yellow, green})
         3'b000: begin
            phase     = PH_OFF;
            multi_hot = 1'b0;
         end
         3'b100: begin
            phase     = PH_RED;
            multi_hot = 1'b0;
         end
         3'b010: begin
            phase     = PH_YELLOW;
            multi_hot = 1'b0;
         end
         3'b001: begin
            phase     = PH_GREEN;
            multi_hot = 1'b0;
         end
         default: begin
            phase     = PH_OFF;
            multi_hot = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/traffic_light_monitor.sv
// -----------------------------------------------------------------------------
// traffic_light_monitor
// Passive checker for a red/yellow/green lamp interface. Samples the lamps
// every rising edge, tracks phase dwell, and checks lamp legality, phase order
// and per-phase duration once locked onto an entry into RED.
// Ports:
//   clk, reset     : clock, asynchronous active-high reset
//   red/yellow/green : lamp lines (observed only)
//   clr_err        : synchronous clear of the sticky error flags
//   phase          : decoded phase of the previous sample (0 OFF,1 R,2 G,3 Y)
//   dwell          : consecutive samples of the current phase, saturating
//   in_sync        : high while tracking
//   cycles         : completed legal R->G->Y->R cycles (wrapping)
//   err_pulse      : one-cycle pulse on any new error
//   lamp_err, order_err, timing_err : sticky error flags
// All outputs are registered: one cycle of latency from lamp sample.
// -----------------------------------------------------------------------------
module traffic_light_monitor
   import traffic_light_monitor_pkg::*;
#(
   parameter int RED_CYCLES    = 5,
   parameter int GREEN_CYCLES  = 4,
   parameter int YELLOW_CYCLES = 2,
   parameter int CNT_W         = 8
)
(
   input  logic                clk,
   input  logic                reset,
   input  logic                red,
   input  logic                yellow,
   input  logic                green,
   input  logic                clr_err,
   output logic [1:0]          phase,
   output logic [CNT_W-1:0]    dwell,
   output logic                in_sync,
   output logic [CYCLES_W-1:0] cycles,
   output logic                err_pulse,
   output logic                lamp_err,
   output logic                order_err,
   output logic                timing_err
);

   localparam logic [CNT_W-1:0] DWELL_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] DWELL_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W:0]   WIDE_ONE  = {{CNT_W{1'b0}}, 1'b1};

   // Required dwell for a phase, one bit wider so expected+1 never overflows.
   function automatic logic [CNT_W:0] exp_dwell(input phase_e ph);
      logic [CNT_W:0] val;
      case (ph)
         PH_RED:    val = (CNT_W+1)'(RED_CYCLES);
         PH_GREEN:  val = (CNT_W+1)'(GREEN_CYCLES);
         PH_YELLOW: val = (CNT_W+1)'(YELLOW_CYCLES);
         default:   val = {(CNT_W+1){1'b0}};
      endcase
      return val;
   endfunction

   phase_e                cur_phase_s;
   logic                  cur_multi_s;

   phase_e                prev_phase_r;
   logic                  prev_multi_r;
   logic                  first_r;
   mon_state_e            state_r;
   logic [CNT_W-1:0]      dwell_r;
   phase_e                phase_r;
   logic                  in_sync_r;
   logic [CYCLES_W-1:0]   cycles_r;
   logic                  err_pulse_r;
   logic                  lamp_err_r;
   logic                  order_err_r;
   logic                  timing_err_r;

   logic                  same_s;
   logic [CNT_W-1:0]      dwell_nxt_s;
   mon_state_e            state_nxt_s;
   logic                  lamp_ev_s;
   logic                  order_ev_s;
   logic                  timing_ev_s;
   logic                  cyc_inc_s;

   traffic_lamp_decode u_decode (
      .red       (red),
      .yellow    (yellow),
      .green     (green),
      .phase     (cur_phase_s),
      .multi_hot (cur_multi_s)
   );

   // Dwell update: restart at 1 on any change (MULTI is its own value), else saturating count.
   always_comb begin
      same_s      = 1'b0;
      dwell_nxt_s = DWELL_ONE;
      if (!first_r && (cur_phase_s == prev_phase_r) && (cur_multi_s == prev_multi_r)) begin
         same_s = 1'b1;
      end else begin
         same_s = 1'b0;
      end
      if (!same_s) begin
         dwell_nxt_s = DWELL_ONE;
      end else if (dwell_r == DWELL_MAX) begin
         dwell_nxt_s = dwell_r;
      end else begin
         dwell_nxt_s = dwell_r + DWELL_ONE;
      end
   end

   // Checker decision for this sample; branch order gives lamp > order > timing priority.
   always_comb begin
      state_nxt_s = state_r;
      lamp_ev_s   = 1'b0;
      order_ev_s  = 1'b0;
      timing_ev_s = 1'b0;
      cyc_inc_s   = 1'b0;
      case (state_r)
         ST_SYNC: begin
            if (cur_multi_s) begin
               lamp_ev_s = 1'b1;
            end else if ((cur_phase_s == PH_RED) && !same_s && !first_r) begin
               // A red already lit on the very first sample is not an entry.
               state_nxt_s = ST_TRACK;
            end else begin
               state_nxt_s = ST_SYNC;
            end
         end
         ST_TRACK: begin
            if (cur_multi_s || (cur_phase_s == PH_OFF)) begin
               lamp_ev_s   = 1'b1;
               state_nxt_s = ST_SYNC;
            end else if (same_s) begin
               // Overstay is flagged on the sample that reaches expected+1.
               if ({1'b0, dwell_nxt_s} == (exp_dwell(cur_phase_s) + WIDE_ONE)) begin
                  timing_ev_s = 1'b1;
                  state_nxt_s = ST_SYNC;
               end else begin
                  state_nxt_s = ST_TRACK;
               end
            end else if (is_legal_step(prev_phase_r, cur_phase_s)) begin
               if ({1'b0, dwell_r} < exp_dwell(prev_phase_r)) begin
                  timing_ev_s = 1'b1;
                  state_nxt_s = ST_SYNC;
               end else if (prev_phase_r == PH_YELLOW) begin
                  cyc_inc_s   = 1'b1;
                  state_nxt_s = ST_TRACK;
               end else begin
                  state_nxt_s = ST_TRACK;
               end
            end else begin
               order_ev_s  = 1'b1;
               state_nxt_s = ST_SYNC;
            end
         end
         default: begin
            state_nxt_s = ST_SYNC;
         end
      endcase
   end

   // Sample history, checker state and all registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev_phase_r <= PH_OFF;
         prev_multi_r <= 1'b0;
         first_r      <= 1'b1;
         state_r      <= ST_SYNC;
         dwell_r      <= {CNT_W{1'b0}};
         phase_r      <= PH_OFF;
         in_sync_r    <= 1'b0;
         cycles_r     <= {CYCLES_W{1'b0}};
         err_pulse_r  <= 1'b0;
         lamp_err_r   <= 1'b0;
         order_err_r  <= 1'b0;
         timing_err_r <= 1'b0;
      end else begin
         prev_phase_r <= cur_phase_s;
         prev_multi_r <= cur_multi_s;
         first_r      <= 1'b0;
         state_r      <= state_nxt_s;
         dwell_r      <= dwell_nxt_s;
         phase_r      <= cur_phase_s;
         in_sync_r    <= (state_nxt_s == ST_TRACK);
         cycles_r     <= cycles_r + {{(CYCLES_W-1){1'b0}}, cyc_inc_s};
         err_pulse_r  <= lamp_ev_s | order_ev_s | timing_ev_s;
         // A same-cycle error outranks clr_err.
         lamp_err_r   <= (lamp_err_r   & ~clr_err) | lamp_ev_s;
         order_err_r  <= (order_err_r  & ~clr_err) | order_ev_s;
         timing_err_r <= (timing_err_r & ~clr_err) | timing_ev_s;
      end
   end

   assign phase      = phase_r;
   assign dwell      = dwell_r;
   assign in_sync    = in_sync_r;
   assign cycles     = cycles_r;
   assign err_pulse  = err_pulse_r;
   assign lamp_err   = lamp_err_r;
   assign order_err  = order_err_r;
   assign timing_err = timing_err_r;

endmodule
